// File: rtl/l2_sio_rsp_arb.sv
// l2_sio_rsp_arb: round-robin arbiter muxing eight L2 bank response packets onto one credited SIO stream.
module l2_sio_rsp_arb #(
  parameter int NREQ = 8,
  parameter int DW = 32,
  parameter int BEATS = 17,
  parameter int CREDITS = 4,
  localparam int CW = $clog2(CREDITS + 1),
  localparam int IW = $clog2(NREQ),
  localparam int BW = $clog2(BEATS)
) (
  input  logic             iol2clk,
  input  logic             rst,
  input  logic [NREQ-1:0]    l2b_req,
  output logic [NREQ-1:0]    l2b_gnt,
  input  logic [NREQ*DW-1:0] l2b_data,
  input  logic [NREQ*2-1:0]  l2b_parity,
  input  logic [NREQ-1:0]    l2b_ue_err,
  output logic             sio_vld,
  output logic             sio_beat,
  output logic [DW-1:0]    sio_data,
  output logic [1:0]       sio_parity,
  output logic             sio_ue_err,
  input  logic             sio_credit_ret,
  output logic [CW-1:0]    credit_cnt,
  output logic             busy,
  output logic             credit_ovf
);
  typedef enum logic [1:0] {IDLE, GNT, XFER} state_e;
  state_e          state_q;
  logic [NREQ-1:0] gnt_q, req_m;
  logic [IW-1:0]   owner_q, rr_q, win;
  logic [BW-1:0]   beat_q;
  logic [CW-1:0]   credit_q;
  logic [DW-1:0]   data_q;
  logic [1:0]      par_q;
  logic            vld_q, beat_o_q, ue_q, ovf_q, found, last, take, xfer;
  // the current owner cannot win again until its packet has been sent
  assign req_m = (state_q == IDLE) ? l2b_req : l2b_req & ~(NREQ'(1) << owner_q);
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req_m[(int'(rr_q) + k) % NREQ]) begin
        win = IW'((int'(rr_q) + k) % NREQ);
        found = 1'b1;
      end
  end
  assign xfer = state_q == XFER;
  assign last = xfer && beat_q == BW'(BEATS - 1);
  assign take = (state_q == IDLE || last) && found && credit_q != '0;
  always_ff @(posedge iol2clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      owner_q  <= '0;
      rr_q     <= '0;
      beat_q   <= '0;
      credit_q <= CW'(CREDITS);
      ovf_q    <= 1'b0;
      vld_q    <= 1'b0;
      beat_o_q <= 1'b0;
      data_q   <= '0;
      par_q    <= '0;
      ue_q     <= 1'b0;
    end else begin
      gnt_q <= take ? (NREQ'(1) << win) : '0;
      if (take) begin
        state_q <= GNT;
        owner_q <= win;
        rr_q    <= (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
        beat_q  <= '0;
      end else if (state_q == GNT) begin
        state_q <= XFER;
      end else if (xfer) begin
        beat_q <= last ? '0 : beat_q + 1'b1;
        if (last) state_q <= IDLE;
      end
      // a grant and a return in the same cycle cancel out
      if (take && !sio_credit_ret)
        credit_q <= credit_q - 1'b1;
      else if (!take && sio_credit_ret) begin
        if (credit_q == CW'(CREDITS)) ovf_q <= 1'b1;
        else credit_q <= credit_q + 1'b1;
      end
      vld_q    <= xfer && beat_q == '0;
      beat_o_q <= xfer;
      data_q   <= xfer ? l2b_data[int'(owner_q)*DW +: DW] : '0;
      par_q    <= xfer ? l2b_parity[int'(owner_q)*2 +: 2] : '0;
      ue_q     <= xfer && l2b_ue_err[owner_q];
    end
  end
  assign l2b_gnt    = gnt_q;
  assign sio_vld    = vld_q;
  assign sio_beat   = beat_o_q;
  assign sio_data   = data_q;
  assign sio_parity = par_q;
  assign sio_ue_err = ue_q;
  assign credit_cnt = credit_q;
  assign busy       = state_q != IDLE;
  assign credit_ovf = ovf_q;
endmodule

// File: doc/l2_sio_rsp_arb.md
# l2_sio_rsp_arb

Round-robin arbiter and sequencer that shares the single SIO outbound response path among the eight L2 banks. Each bank requests, receives a one-cycle grant, then streams a fixed-length packet: a ctag header beat followed by data beats. The block muxes the granted bank's beats onto one registered output stream. It meters packets against downstream SIO buffer credits.

## Interface
- NREQ, 8, number of L2 bank requesters
- DW, 32, beat data width
- BEATS, 17, beats per packet (1 header + 16 data)
- CREDITS, 4, downstream packet buffers; CW = clog2(CREDITS+1)
- iol2clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- l2b_req  in  NREQ  bank i has a packet pending; held high until its gnt, then dropped
- l2b_gnt  out  NREQ  one-hot, one-cycle grant
- l2b_data  in  NREQ*DW  bank i beat data, slice [i*DW +: DW]
- l2b_parity  in  NREQ*2  bank i beat parity, slice [i*2 +: 2]
- l2b_ue_err  in  NREQ  bank i uncorrectable error, per beat
- sio_vld  out  1  high on output header beat only
- sio_beat  out  1  high on every output beat of a packet
- sio_data  out  DW  forwarded beat data
- sio_parity  out  2  forwarded parity
- sio_ue_err  out  1  forwarded ue_err of owner, beats only
- sio_credit_ret  in  1  one-cycle pulse, SIO freed one packet buffer
- credit_cnt  out  CW  available credits
- busy  out  1  state != IDLE
- credit_ovf  out  1  sticky: credit returned while credit_cnt == CREDITS

## Operation
- Reset values: l2b_gnt 0; sio_* 0; credit_cnt CREDITS; busy 0; credit_ovf 0; rr_ptr 0; state IDLE; beat_cnt 0.
- States: IDLE, GNT, XFER.
- IDLE: if |l2b_req and credit_cnt != 0, go to GNT.
  - Winner is the first set req at or above rr_ptr, wrapping modulo NREQ.
  - Registered: l2b_gnt <= onehot(winner), owner <= winner, rr_ptr <= (winner+1) mod NREQ, beat_cnt <= 0.
- GNT: lasts 1 cycle with l2b_gnt high, then XFER. The owner drives its header beat in the cycle after gnt.
- XFER: each cycle, the owner's data/parity/ue_err are sampled and registered to the sio_* outputs.
  - sio_beat = 1 on every beat; sio_vld = 1 when beat_cnt == 0.
  - beat_cnt increments each cycle.
- At beat_cnt == BEATS-1:
  - If another req is pending and credit_cnt != 0 (registered value), go directly to GNT; the same arbitration rules as IDLE apply.
  - Otherwise go to IDLE.
- Outside XFER-sourced cycles, sio_vld, sio_beat, sio_data, sio_parity and sio_ue_err are 0.
- Credits (CW-bit count):
  - Decrement on entry to GNT; increment on sio_credit_ret.
  - Both in the same cycle: count unchanged.
  - sio_credit_ret at CREDITS with no simultaneous grant: count holds and credit_ovf sets (cleared only by rst).
  - Never decrement below 0; a grant requires credit_cnt != 0.
- A req dropped before grant is simply not granted; no error is flagged.
- Owner's req is ignored from GNT onward; the owner may re-request after its packet and competes normally.

## Timing
- Grant in cycle A: input header at A+1, output header (sio_vld) at A+2, last output beat at A+BEATS+1.
- Minimum packet spacing is BEATS+1 cycles; the GNT cycle overlaps the previous packet's last output beat.
- credit_ret pulse in cycle C with credit_cnt 0 and a req waiting: credit_cnt = 1 in C+1, gnt in C+2.
- Input-to-output latency for every beat: exactly 1 cycle.
- rst asserted mid-packet: all outputs take reset values asynchronously and the packet is truncated. After release, arbitration restarts with rr_ptr 0 and full credits.

## Test plan
- Bank 3 req alone after reset, data = 0x300+k on beat k -> gnt[3] for 1 cycle; sio_vld 2 cycles later; 17 sio_beat cycles carrying 0x300..0x310; credit_cnt 3; busy low after the last beat.
- All 8 reqs at once, credit_ret pulsed each packet -> grants in order 0,1,…,7, each 18 cycles apart, no idle cycles between packets.
- 5 reqs (banks 0–4), no returns -> 4 packets then stall with credit_cnt 0 and busy 0. credit_ret in cycle C -> gnt[4] at C+2.
- credit_ret coincident with a grant at credit_cnt 2 -> credit_cnt stays 2. credit_ret at credit_cnt 4 with no grant -> credit_cnt 4, credit_ovf 1 and held.
- Bank 2 asserts ue_err on input beat 5 only -> sio_ue_err high only on output beat 5; sio_parity matches input on every beat.
- rst during XFER at beat_cnt 8 -> all outputs 0 and credit_cnt 4 immediately. After release with banks 5 and 1 requesting -> bank 1 granted first.
